// File: rtl/dmem_arbiter_if.sv
// Requester/memory bundle for dmem_arbiter.
// slave = arbiter side; master = requesters plus the memory model.
interface dmem_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              req0, req1;
   logic              we0, we1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              gnt0, gnt1;
   logic              done0, done1;
   logic              err0, err1;
   logic [DATA_W-1:0] rdata0, rdata1;
   logic              mem_rw;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      output gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
             mem_rw, mem_addr, mem_wdata, busy
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      input  gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
             mem_rw, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for a single-port data memory: IDLE -> ACCESS -> RESP per transaction.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default is round-robin.
module dmem_arbiter #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MEM_DEPTH = 32
) (
   input logic           clk_i,
   input logic           rst_i,
   dmem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   state_e            state_q, state_d;
   logic              win_q, win_d;
   logic              we_q, we_d;
   logic              oor_q, oor_d;
   logic [1:0]        gnt_q, gnt_d;
   logic [1:0]        done_q, done_d;
   logic [1:0]        err_q, err_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              mem_rw_q, mem_rw_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              busy_q, busy_d;

   logic              win_c;
   logic              sel_we_c;
   logic [ADDR_W-1:0] sel_addr_c;
   logic [DATA_W-1:0] sel_wdata_c;
   logic              sel_oor_c;
   logic [DATA_W-1:0] ld_data_c;

`ifdef DMEM_ARB_FIXED_PRIO_EN
   assign win_c = ~bus.req0;
`else
   // prio_q names the port preferred on the next contention
   logic prio_q, prio_d;
   assign win_c = (bus.req0 & bus.req1) ? prio_q : bus.req1;
`endif

   assign sel_we_c    = win_c ? bus.we1    : bus.we0;
   assign sel_addr_c  = win_c ? bus.addr1  : bus.addr0;
   assign sel_wdata_c = win_c ? bus.wdata1 : bus.wdata0;
   assign sel_oor_c   = (sel_addr_c >= ADDR_W'(MEM_DEPTH));
   assign ld_data_c   = oor_q ? '0 : bus.mem_rdata;

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      we_d        = we_q;
      oor_d       = oor_q;
      gnt_d       = '0;
      done_d      = '0;
      err_d       = '0;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      mem_rw_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      prio_d      = prio_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.req0 | bus.req1) begin
               state_d     = ACCESS;
               win_d       = win_c;
               we_d        = sel_we_c;
               oor_d       = sel_oor_c;
               mem_addr_d  = sel_addr_c;
               mem_wdata_d = sel_wdata_c;
               mem_rw_d    = sel_we_c & ~sel_oor_c;
               gnt_d[win_c] = 1'b1;
`ifndef DMEM_ARB_FIXED_PRIO_EN
               prio_d      = ~win_c;
`endif
            end
         end
         ACCESS: begin
            state_d        = RESP;
            done_d[win_q]  = 1'b1;
            err_d[win_q]   = oor_q;
            if (!we_q) begin
               if (win_q) rdata1_d = ld_data_c;
               else       rdata0_d = ld_data_c;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         win_q       <= 1'b0;
         we_q        <= 1'b0;
         oor_q       <= 1'b0;
         gnt_q       <= '0;
         done_q      <= '0;
         err_q       <= '0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         mem_rw_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
         prio_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         win_q       <= win_d;
         we_q        <= we_d;
         oor_q       <= oor_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         err_q       <= err_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
         mem_rw_q    <= mem_rw_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
         prio_q      <= prio_d;
`endif
      end
   end

   assign bus.gnt0      = gnt_q[0];
   assign bus.gnt1      = gnt_q[1];
   assign bus.done0     = done_q[0];
   assign bus.done1     = done_q[1];
   assign bus.err0      = err_q[0];
   assign bus.err1      = err_q[1];
   assign bus.rdata0    = rdata0_q;
   assign bus.rdata1    = rdata1_q;
   assign bus.mem_rw    = mem_rw_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter against a transaction-level model
// (reference memory, last-grant pointer, expected rdata per port).
module tb_dmem_arbiter;

   localparam int unsigned DEPTH = 32;

   logic clk;
   logic rst;

   dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(DEPTH)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   // Memory attached to the DUT
   logic [31:0] mem [0:DEPTH-1];
   assign bus.mem_rdata = (bus.mem_addr < 32'(DEPTH)) ? mem[bus.mem_addr[4:0]] : 32'h0;
   always @(posedge clk) begin
      if (bus.mem_rw && bus.mem_addr < 32'(DEPTH)) mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          nvec;
   int          nerr;
   logic [31:0] ref_mem [0:DEPTH-1];
   logic [31:0] exp_rdata [2];
   int          last_grant;
   logic        we_v [2];
   logic [31:0] addr_v [2];
   logic [31:0] wdata_v [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_port(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
      we_v[p]    = we;
      addr_v[p]  = a;
      wdata_v[p] = d;
   endtask

   task automatic drive(input bit r0, input bit r1);
      bus.req0 = r0;  bus.we0 = we_v[0]; bus.addr0 = addr_v[0]; bus.wdata0 = wdata_v[0];
      bus.req1 = r1;  bus.we1 = we_v[1]; bus.addr1 = addr_v[1]; bus.wdata1 = wdata_v[1];
   endtask

   // Call just after a negedge with the DUT idle; serves every requesting port
   task automatic run_txns(input bit r0, input bit r1);
      bit p [2];
      int w;
      bit inr;
      p[0] = r0;
      p[1] = r1;
      drive(r0, r1);
      while (p[0] || p[1]) begin
         if (p[0] && p[1]) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            w = 0;
`else
            w = (last_grant == 0) ? 1 : 0;
`endif
         end else begin
            w = p[1] ? 1 : 0;
         end
         last_grant = w;
         inr = (addr_v[w] < 32'(DEPTH));

         @(negedge clk);
         chk("gnt0",     32'(bus.gnt0),   32'(w == 0));
         chk("gnt1",     32'(bus.gnt1),   32'(w == 1));
         chk("busy_acc", 32'(bus.busy),   32'(1));
         chk("mem_rw",   32'(bus.mem_rw), 32'(we_v[w] && inr));
         chk("mem_addr", bus.mem_addr,    addr_v[w]);
         if (we_v[w]) chk("mem_wdata", bus.mem_wdata, wdata_v[w]);
         if (we_v[w] && inr) ref_mem[addr_v[w][4:0]] = wdata_v[w];
         else if (!we_v[w]) exp_rdata[w] = inr ? ref_mem[addr_v[w][4:0]] : 32'h0;
         p[w] = 1'b0;
         drive(p[0], p[1]);

         @(negedge clk);
         chk("done0",     32'(bus.done0),  32'(w == 0));
         chk("done1",     32'(bus.done1),  32'(w == 1));
         chk("err0",      32'(bus.err0),   32'(w == 0 && !inr));
         chk("err1",      32'(bus.err1),   32'(w == 1 && !inr));
         chk("rdata0",    bus.rdata0,      exp_rdata[0]);
         chk("rdata1",    bus.rdata1,      exp_rdata[1]);
         chk("rw_resp",   32'(bus.mem_rw), 32'(0));
         chk("gnt_resp",  32'({bus.gnt1, bus.gnt0}), 32'(0));

         @(negedge clk);
         chk("busy_idle", 32'(bus.busy), 32'(0));
         chk("done_idle", 32'({bus.done1, bus.done0}), 32'(0));
      end
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      last_grant = 1;
      exp_rdata[0] = 32'h0;
      exp_rdata[1] = 32'h0;
      for (int i = 0; i < 2; i++) set_port(i, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy",   32'(bus.busy),   32'(0));
      chk("rst_mem_rw", 32'(bus.mem_rw), 32'(0));
      chk("rst_pulses", 32'({bus.gnt1, bus.gnt0, bus.done1, bus.done0, bus.err1, bus.err0}), 32'(0));
      chk("rst_rdata0", bus.rdata0,    32'h0);
      chk("rst_rdata1", bus.rdata1,    32'h0);
      chk("rst_maddr",  bus.mem_addr,  32'h0);
      chk("rst_mwdata", bus.mem_wdata, 32'h0);
      rst = 1'b0;

      // Preload the whole memory through port 0 stores
      for (int a = 0; a < int'(DEPTH); a++) begin
         set_port(0, 1'b1, 32'(a), (a == 1) ? 32'h11 : (a == 2) ? 32'h22 : $urandom);
         run_txns(1'b1, 1'b0);
      end

      // Store then load on port 0
      set_port(0, 1'b1, 32'd5, 32'hDEADBEEF);
      run_txns(1'b1, 1'b0);
      set_port(0, 1'b0, 32'd5, 32'h0);
      run_txns(1'b1, 1'b0);
      chk("ld5_value", exp_rdata[0], 32'hDEADBEEF);

      // Contention, a lone port 0 access, then contention again
      set_port(0, 1'b0, 32'd1, 32'h0);
      set_port(1, 1'b0, 32'd2, 32'h0);
      run_txns(1'b1, 1'b1);
      run_txns(1'b1, 1'b0);
      run_txns(1'b1, 1'b1);

      // Out-of-range store and load on port 1
      set_port(1, 1'b1, 32'd40, 32'hCAFEF00D);
      run_txns(1'b0, 1'b1);
      set_port(1, 1'b0, 32'd8, 32'h0);
      run_txns(1'b0, 1'b1);
      set_port(1, 1'b0, 32'd33, 32'h0);
      run_txns(1'b0, 1'b1);

      // Reset during the ACCESS cycle of a port 0 load
      set_port(0, 1'b0, 32'd7, 32'h0);
      drive(1'b1, 1'b0);
      @(negedge clk);
      chk("rstmid_gnt0", 32'(bus.gnt0), 32'(1));
      rst = 1'b1;
      drive(1'b0, 1'b0);
      @(negedge clk);
      chk("rstmid_done0", 32'(bus.done0),  32'(0));
      chk("rstmid_busy",  32'(bus.busy),   32'(0));
      chk("rstmid_rw",    32'(bus.mem_rw), 32'(0));
      chk("rstmid_gnt0b", 32'(bus.gnt0),   32'(0));
      rst = 1'b0;
      exp_rdata[0] = 32'h0;
      exp_rdata[1] = 32'h0;
      last_grant = 1;
      @(negedge clk);
      chk("rstmid_done0b", 32'(bus.done0), 32'(0));
      run_txns(1'b1, 1'b0);

      // req0 held high: one grant every third cycle
      set_port(0, 1'b0, 32'd3, 32'h0);
      drive(1'b1, 1'b0);
      for (int n = 1; n <= 9; n++) begin
         @(negedge clk);
         chk("held_gnt0", 32'(bus.gnt0), 32'(n % 3 == 1));
         chk("held_busy", 32'(bus.busy), 32'(n % 3 != 0));
         if (n % 3 == 2) chk("held_rdata0", bus.rdata0, ref_mem[3]);
         if (n == 9) drive(1'b0, 1'b0);
      end
      exp_rdata[0] = ref_mem[3];
      last_grant = 0;

      // Randomized traffic, addresses include out-of-range values
      for (int it = 0; it < 60; it++) begin
         bit r0, r1;
         r0 = 1'($urandom % 2);
         r1 = 1'($urandom % 2);
         if (!r0 && !r1) r0 = 1'b1;
         for (int p = 0; p < 2; p++)
            set_port(p, 1'($urandom % 2), 32'($urandom_range(0, 39)), $urandom);
         run_txns(r0, r1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
